fetch_controller: RTL and testbench

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_controller.sv | 123 ++++++++++++
 tb/tb_fetch_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Instruction fetch controller: BOOT/FETCH/HALT sequencer driving an 8-bit word-addressed imem.
// Optional macro FETCH_HALT_ON_ZERO_EN: an all-zero instruction halts fetch instead of issuing.
module fetch_controller #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [7:0]       imem_addr,
  input  logic [31:0]      imem_ins,
  input  logic             stall,
  input  logic             redirect,
  input  logic [7:0]       redirect_pc,
  input  logic             resume,
  output logic [31:0]      ins,
  output logic [7:0]       ins_pc,
  output logic             ins_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [AW-1:0]    pc, pc_n;
  logic [DW-1:0]    ins_n;
  logic [AW-1:0]    ins_pc_n;
  logic             ins_valid_n;
  logic [CNT_W-1:0] cnt_n;
  logic             zero_hit;

  assign imem_addr = pc;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_hit = (imem_ins == DW'(0));
`else
  assign zero_hit = 1'b0;
`endif

  // Next-state and next-register values; every branch starts from "hold".
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    ins_n       = ins;
    ins_pc_n    = ins_pc;
    ins_valid_n = ins_valid;
    cnt_n       = fetch_count;
    case (state)
      BOOT: begin
        ins_valid_n = 1'b0;
        state_n     = FETCH;
      end
      FETCH: begin
        if (redirect) begin
          pc_n        = redirect_pc;
          ins_valid_n = 1'b0;
        end else if (!stall) begin
          if (zero_hit) begin
            // Halt parks pc on the zero word so a resume steps past it.
            ins_valid_n = 1'b0;
            state_n     = HALT;
          end else begin
            ins_n       = imem_ins;
            ins_pc_n    = pc;
            ins_valid_n = 1'b1;
            pc_n        = pc + AW'(1);
            if (!(&fetch_count)) cnt_n = fetch_count + CNT_W'(1);
          end
        end
      end
      HALT: begin
        ins_valid_n = 1'b0;
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = FETCH;
        end else if (resume) begin
          pc_n    = pc + AW'(1);
          state_n = FETCH;
        end
      end
      default: begin
        ins_valid_n = 1'b0;
        state_n     = BOOT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      ins         <= '0;
      ins_pc      <= '0;
      ins_valid   <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      ins         <= ins_n;
      ins_pc      <= ins_pc_n;
      ins_valid   <= ins_valid_n;
      fetch_count <= cnt_n;
    end
  end

`ifdef FETCH_HALT_ON_ZERO_EN
  always_ff @(posedge clk) begin
    if (rst) halted <= 1'b0;
    else     halted <= (state_n == HALT);
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed vector table, corner sequences and
// randomized run against a behavioural model; honours FETCH_HALT_ON_ZERO_EN.
module tb_fetch_controller;

  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, stall, redirect, resume;
  logic [7:0]    redirect_pc;
  logic [7:0]    imem_addr;
  logic [31:0]   imem_ins;
  logic [31:0]   ins;
  logic [7:0]    ins_pc;
  logic          ins_valid, halted;
  logic [CW-1:0] fetch_count;

  logic [31:0] mem [256];
  assign imem_ins = mem[imem_addr];

  int checks = 0;
  int errors = 0;

  fetch_controller #(.RESET_PC(8'h00), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_ins(imem_ins),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .resume(resume),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .halted(halted),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, redirect, resume;
    logic [7:0]  rpc;
    logic [31:0] e_ins;
    logic [7:0]  e_pc, e_addr;
    logic        e_valid, e_halted;
    int          e_cnt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic r, logic s, logic rd, logic rs, logic [7:0] rpc,
                              logic [31:0] ei, logic [7:0] ep, logic ev, logic [7:0] ea,
                              int ec, logic eh);
    vec_t v;
    v.rst = r; v.stall = s; v.redirect = rd; v.resume = rs; v.rpc = rpc;
    v.e_ins = ei; v.e_pc = ep; v.e_valid = ev; v.e_addr = ea; v.e_cnt = ec; v.e_halted = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic rs,
                       input logic [7:0] rpc);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; resume = rs; redirect_pc = rpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'hAABBCCDD;
    mem[1]   = 32'h11223344;
    mem[255] = 32'hCCDDEEFF;
  endtask

  // Behavioural reference: mode 0=boot, 1=running, 2=halted.
  int          m_mode;
  logic [7:0]  m_pc, m_ins_pc;
  logic [31:0] m_ins;
  logic        m_valid;
  int          m_cnt;

  task automatic model_reset();
    m_mode = 0; m_pc = 8'h00; m_ins = 32'h0; m_ins_pc = 8'h0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic r, input logic s, input logic rd, input logic rs,
                            input logic [7:0] rpc);
    logic [31:0] word;
    if (r) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      m_valid = 1'b0;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (rd) begin
        m_pc = rpc;
        m_valid = 1'b0;
      end else if (!s) begin
        word = mem[m_pc];
        if (HALT_EN && word == 32'h0) begin
          m_valid = 1'b0;
          m_mode = 2;
        end else begin
          m_ins = word;
          m_ins_pc = m_pc;
          m_valid = 1'b1;
          m_pc = 8'((int'(m_pc) + 1) % 256);
          if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
      end
    end else begin
      m_valid = 1'b0;
      if (rd) begin
        m_pc = rpc; m_mode = 1;
      end else if (rs) begin
        m_pc = 8'((int'(m_pc) + 1) % 256); m_mode = 1;
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; resume = 1'b0; redirect_pc = 8'h00;
    load_image();

    // Directed table: inputs for one edge, outputs expected right after it.
    tbl[0]  = mk(1,0,0,0,8'h00, 32'h0,        8'h00, 0, 8'h00, 0, 0);
    tbl[1]  = mk(0,0,0,0,8'h00, 32'h0,        8'h00, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0,0,0,0,8'h00, 32'hAABBCCDD, 8'h00, 1, 8'h01, 1, 0);
    tbl[3]  = mk(0,1,0,0,8'h00, 32'hAABBCCDD, 8'h00, 1, 8'h01, 1, 0);
    tbl[4]  = mk(0,1,0,0,8'h00, 32'hAABBCCDD, 8'h00, 1, 8'h01, 1, 0);
    tbl[5]  = mk(0,1,0,0,8'h00, 32'hAABBCCDD, 8'h00, 1, 8'h01, 1, 0);
    tbl[6]  = mk(0,0,0,0,8'h00, 32'h11223344, 8'h01, 1, 8'h02, 2, 0);
    tbl[7]  = mk(0,1,1,0,8'hFF, 32'h11223344, 8'h01, 0, 8'hFF, 2, 0);
    tbl[8]  = mk(0,0,0,0,8'h00, 32'hCCDDEEFF, 8'hFF, 1, 8'h00, 3, 0);
    tbl[9]  = mk(0,0,0,0,8'h00, 32'hAABBCCDD, 8'h00, 1, 8'h01, 4, 0);
    tbl[10] = mk(0,0,0,0,8'h00, 32'h11223344, 8'h01, 1, 8'h02, 5, 0);
`ifdef FETCH_HALT_ON_ZERO_EN
    tbl[11] = mk(0,0,0,0,8'h00, 32'h11223344, 8'h01, 0, 8'h02, 5, 1);
    tbl[12] = mk(0,1,0,0,8'h00, 32'h11223344, 8'h01, 0, 8'h02, 5, 1);
    tbl[13] = mk(0,0,0,1,8'h00, 32'h11223344, 8'h01, 0, 8'h03, 5, 0);
    tbl[14] = mk(0,0,0,0,8'h00, 32'h11223344, 8'h01, 0, 8'h03, 5, 1);
`else
    tbl[11] = mk(0,0,0,0,8'h00, 32'h0,        8'h02, 1, 8'h03, 6, 0);
    tbl[12] = mk(0,1,0,0,8'h00, 32'h0,        8'h02, 1, 8'h03, 6, 0);
    tbl[13] = mk(0,0,0,1,8'h00, 32'h0,        8'h03, 1, 8'h04, 7, 0);
    tbl[14] = mk(0,0,0,0,8'h00, 32'h0,        8'h04, 1, 8'h05, 8, 0);
`endif
    tbl[15] = mk(1,1,0,1,8'h00, 32'h0,        8'h00, 0, 8'h00, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redirect, tbl[i].resume, tbl[i].rpc);
      tick();
      chk($sformatf("vec%0d.ins", i),       ins,              tbl[i].e_ins);
      chk($sformatf("vec%0d.ins_pc", i),    32'(ins_pc),      32'(tbl[i].e_pc));
      chk($sformatf("vec%0d.ins_valid", i), 32'(ins_valid),   32'(tbl[i].e_valid));
      chk($sformatf("vec%0d.imem_addr", i), 32'(imem_addr),   32'(tbl[i].e_addr));
      chk($sformatf("vec%0d.fetch_count", i), 32'(fetch_count), 32'(tbl[i].e_cnt));
      chk($sformatf("vec%0d.halted", i),    32'(halted),      32'(tbl[i].e_halted));
    end

    // Counter saturation: many back-to-back fetches of nonzero words.
    for (int i = 0; i < 256; i++) mem[i] = 32'h100 + 32'(i);
    drive(1,0,0,0,8'h00); tick();
    drive(0,0,0,0,8'h00); tick();
    for (int i = 0; i < 20; i++) begin
      drive(0,0,0,0,8'h00); tick();
    end
    chk("sat.fetch_count", 32'(fetch_count), 32'(CNT_MAX));
    chk("sat.ins_pc",      32'(ins_pc),      32'd19);
    chk("sat.ins",         ins,              32'h113);
    chk("sat.imem_addr",   32'(imem_addr),   32'd20);

    // Randomized run against the model, with occasional resets.
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
    drive(1,0,0,0,8'h00);
    model_step(1,0,0,0,8'h00);
    tick();
    for (int n = 0; n < 3000; n++) begin
      logic r, s, rd, rs;
      logic [7:0] rpc;
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      rs  = ($urandom_range(0, 2) == 0);
      rpc = 8'($urandom_range(0, 255));
      drive(r, s, rd, rs, rpc);
      model_step(r, s, rd, rs, rpc);
      tick();
      chk("rnd.ins",         ins,              m_ins);
      chk("rnd.ins_pc",      32'(ins_pc),      32'(m_ins_pc));
      chk("rnd.ins_valid",   32'(ins_valid),   32'(m_valid));
      chk("rnd.imem_addr",   32'(imem_addr),   32'(m_pc));
      chk("rnd.fetch_count", 32'(fetch_count), 32'(m_cnt));
      chk("rnd.halted",      32'(halted),      32'(m_mode == 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
